lmsm_sequencer: RTL and testbench

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// ---------------------------------------------------------------------------
// lmsm_sequencer
//
// Multi-cycle sequencer for load-multiple (LM) and store-multiple (SM).
// Once an operation is accepted from EX it stalls the front of the pipeline.
// It then walks the 8-bit register list from the lowest index upwards and
// makes one memory access per selected register, at consecutive addresses
// starting at the base. The address wraps modulo 2^ADDR_W.
//
// Optional feature (compile-time macro LMSM_BASE_UPDATE_EN):
//   adds an UPD state before FIN. UPD writes base + N back to R[in_ra].
//   Without the macro, in_ra is ignored.
//
// Ports
//   clk1, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready    operation handshake from EX (ready only in IDLE)
//   in_is_store          1 = SM, 0 = LM
//   in_base, in_rlist    start address and register list
//   in_ra                base register index (base-update feature only)
//   busy                 stall request to IF/ID/RR/EX (RUN, UPD, FIN)
//   mem_*                single-beat memory request/response port
//   rf_rd_addr/rf_rd_data combinational register-file read (SM data)
//   rf_we/rf_wa/rf_wd    register-file write port (LM data, base update)
//   done                 one-cycle completion pulse
// ---------------------------------------------------------------------------
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [7:0]        in_rlist,
    input  logic [2:0]        in_ra,
    output logic              busy,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_we,
    output logic [2:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
`ifdef LMSM_BASE_UPDATE_EN
        , UPD
`endif
    } state_t;

    // State entered once the register list is exhausted (or was empty).
`ifdef LMSM_BASE_UPDATE_EN
    localparam state_t POST_RUN = UPD;
`else
    localparam state_t POST_RUN = FIN;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        rlist_q;      // registers still to transfer
    logic [3:0]        cnt_q;        // registers already transferred (0..8)
    logic              is_store_q;
    logic              wr_pend_q;    // LM register write owed this cycle
    logic [2:0]        wr_idx_q;
    logic [DATA_W-1:0] wr_data_q;
`ifdef LMSM_BASE_UPDATE_EN
    logic [2:0]        ra_q;
`else
    logic              unused_ra;
    assign unused_ra = ^in_ra;
`endif

    logic [2:0]        cur_idx;
    logic [7:0]        cur_mask;
    logic [ADDR_W-1:0] addr_sum;
    logic              accept;
    logic              handshake;
    logic              last;

    // Lowest-index pending register. Scanning downwards lets the lowest set
    // bit be the final assignment.
    always_comb begin
        cur_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rlist_q[i]) cur_idx = 3'(i);
        end
    end

    assign cur_mask  = 8'b1 << cur_idx;
    assign addr_sum  = base_q + ADDR_W'(cnt_q);
    assign accept    = (state_q == IDLE) && in_valid;
    assign handshake = (state_q == RUN) && mem_ready;
    assign last      = (rlist_q & ~cur_mask) == 8'd0;

    // Next state and outputs.
    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned; an unassigned path would infer a latch.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_rd_addr = 3'd0;
        rf_we      = wr_pend_q;
        rf_wa      = wr_idx_q;
        rf_wd      = wr_data_q;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_rlist != 8'd0) ? RUN : POST_RUN;
            end
            RUN: begin
                busy      = 1'b1;
                mem_valid = 1'b1;
                mem_we    = is_store_q;
                mem_addr  = addr_sum;
                if (is_store_q) begin
                    rf_rd_addr = cur_idx;
                    mem_wdata  = rf_rd_data;
                end
                if (mem_ready && last) state_d = POST_RUN;
            end
`ifdef LMSM_BASE_UPDATE_EN
            UPD: begin
                // cnt_q equals N here, so addr_sum is base + N.
                busy    = 1'b1;
                rf_we   = 1'b1;
                rf_wa   = ra_q;
                rf_wd   = DATA_W'(addr_sum);
                state_d = FIN;
            end
`endif
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset along with the control state.
    // They are few and cheap to reset, and the data outputs derived from
    // them read zero during reset.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            rlist_q    <= 8'd0;
            cnt_q      <= 4'd0;
            is_store_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= 3'd0;
            wr_data_q  <= '0;
`ifdef LMSM_BASE_UPDATE_EN
            ra_q       <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            wr_pend_q <= 1'b0;

            if (accept) begin
                base_q     <= in_base;
                rlist_q    <= in_rlist;
                cnt_q      <= 4'd0;
                is_store_q <= in_is_store;
`ifdef LMSM_BASE_UPDATE_EN
                ra_q       <= in_ra;
`endif
            end

            if (handshake) begin
                rlist_q <= rlist_q & ~cur_mask;
                cnt_q   <= cnt_q + 4'd1;
                if (!is_store_q) begin
                    wr_pend_q <= 1'b1;
                    wr_idx_q  <= cur_idx;
                    wr_data_q <= mem_rdata;
                end
            end

`ifdef LMSM_BASE_UPDATE_EN
            // UPD owns the write port. The last LM write, due in the same
            // cycle, moves to FIN. It is dropped if it targets the base
            // register, because the base update is the later write.
            if (state_q == UPD) wr_pend_q <= wr_pend_q && (wr_idx_q != ra_q);
`endif
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lmsm_sequencer
//
// Directed bench for lmsm_sequencer. It models a 64K-word memory and an
// 8-entry register file. Expected values are hand-computed constants.
// Expected latencies include an extra cycle when LMSM_BASE_UPDATE_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_lmsm_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
`ifdef LMSM_BASE_UPDATE_EN
    localparam int UPD = 1;
`else
    localparam int UPD = 0;
`endif

    logic              clk1;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_store;
    logic [ADDR_W-1:0] in_base;
    logic [7:0]        in_rlist;
    logic [2:0]        in_ra;
    logic              busy;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_we;
    logic [2:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              done;

    logic [DATA_W-1:0] mem [0:65535];
    logic [DATA_W-1:0] rf  [0:7];
    logic [ADDR_W-1:0] acc_q [$];
    int                valid_cnt;
    int                rfwe_cnt;
    int                n_pass;
    int                n_total;

    lmsm_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_store(in_is_store),
        .in_base    (in_base),
        .in_rlist   (in_rlist),
        .in_ra      (in_ra),
        .busy       (busy),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .done       (done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    assign mem_rdata  = mem[mem_addr];
    assign rf_rd_data = rf[rf_rd_addr];

    // Memory and register-file models plus access logging.
    always @(posedge clk1) begin
        if (mem_valid) valid_cnt++;
        if (mem_valid && mem_ready) begin
            acc_q.push_back(mem_addr);
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
        if (rf_we) begin
            rf[rf_wa] = rf_wd;
            rfwe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Presents one operation. Returns at the negedge of the first cycle
    // after the accept edge.
    task automatic issue(input logic st, input logic [15:0] base,
                         input logic [7:0] rl, input logic [2:0] ra);
        @(negedge clk1);
        acc_q.delete();
        valid_cnt = 0;
        rfwe_cnt  = 0;
        check("in_ready_idle", in_ready, 1);
        in_valid    = 1'b1;
        in_is_store = st;
        in_base     = base;
        in_rlist    = rl;
        in_ra       = ra;
        @(negedge clk1);
        in_valid = 1'b0;
        in_rlist = 8'h00;
    endtask

    // Counts cycles after the accept until done is seen (bounded). Then
    // checks that done lasts only one cycle.
    task automatic wait_done(input string tag, input int start, input int exp);
        int c = start;
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk1);
            c++;
        end
        check(tag, c, exp);
        @(negedge clk1);
        check({tag, "_one_shot"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; valid_cnt = 0; rfwe_cnt = 0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        in_valid = 1'b0; in_is_store = 1'b0; in_base = '0; in_rlist = 8'h00; in_ra = 3'd0;
        mem_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rf_wd", rf_wd, 0);
        @(negedge clk1);
        @(negedge clk1);
        rst_n = 1'b1;

        // LM base 0x0010, rlist 0x05
        mem[16'h0010] = 16'hAAAA;
        mem[16'h0011] = 16'hBBBB;
        issue(1'b0, 16'h0010, 8'h05, 3'd5);
        check("lm_busy", busy, 1);
        check("lm_in_ready_low", in_ready, 0);
        check("lm_addr0", mem_addr, 16'h0010);
        check("lm_we0", mem_we, 0);
        @(negedge clk1);
        check("lm_addr1", mem_addr, 16'h0011);
        check("lm_rf_we_r0", rf_we, 1);
        check("lm_rf_wa_r0", rf_wa, 0);
        check("lm_rf_wd_r0", rf_wd, 16'hAAAA);
        wait_done("lm_latency", 2, 3 + UPD);
        check("lm_r0", rf[0], 16'hAAAA);
        check("lm_r2", rf[2], 16'hBBBB);
        check("lm_r1_untouched", rf[1], 16'h0000);
        check("lm_r5_base_upd", rf[5], UPD ? 16'h0012 : 16'h0000);
        check("lm_access_cnt", acc_q.size(), 2);

        // LM address wrap
        mem[16'hFFFF] = 16'h1111;
        mem[16'h0000] = 16'h2222;
        issue(1'b0, 16'hFFFF, 8'h03, 3'd6);
        wait_done("wrap_latency", 1, 3 + UPD);
        check("wrap_access_cnt", acc_q.size(), 2);
        check("wrap_addr0", acc_q[0], 16'hFFFF);
        check("wrap_addr1", acc_q[1], 16'h0000);
        check("wrap_r0", rf[0], 16'h1111);
        check("wrap_r1", rf[1], 16'h2222);

        // Empty register list
        issue(1'b0, 16'h0042, 8'h00, 3'd3);
        check("empty_no_valid_c1", mem_valid, 0);
        wait_done("empty_latency", 1, 1 + UPD);
        check("empty_valid_cnt", valid_cnt, 0);
        check("empty_r3", rf[3], UPD ? 16'h0042 : 16'h0000);

        // SM with a two-cycle stall on the first access
        rf[0] = 16'h1234;
        rf[7] = 16'h5678;
        mem_ready = 1'b0;
        issue(1'b1, 16'h0100, 8'h81, 3'd4);
        check("sm_addr_c1", mem_addr, 16'h0100);
        check("sm_we_c1", mem_we, 1);
        check("sm_rd_addr_c1", rf_rd_addr, 0);
        check("sm_wdata_c1", mem_wdata, 16'h1234);
        @(negedge clk1);
        check("sm_addr_hold_c2", mem_addr, 16'h0100);
        check("sm_wdata_hold_c2", mem_wdata, 16'h1234);
        check("sm_we_hold_c2", mem_we, 1);
        @(negedge clk1);
        check("sm_addr_hold_c3", mem_addr, 16'h0100);
        mem_ready = 1'b1;
        @(negedge clk1);
        check("sm_addr_c4", mem_addr, 16'h0101);
        check("sm_wdata_c4", mem_wdata, 16'h5678);
        wait_done("sm_latency", 4, 5 + UPD);
        check("sm_mem100", mem[16'h0100], 16'h1234);
        check("sm_mem101", mem[16'h0101], 16'h5678);
        check("sm_rf_we_cnt", rfwe_cnt, UPD);
        check("sm_r4_base_upd", rf[4], UPD ? 16'h0102 : 16'h0000);

        // Reset during the (stalled) third access of LM rlist 0xFF
        for (int i = 0; i < 8; i++) begin
            rf[i] = '0;
            mem[16'h0200 + i] = 16'hC200 + 16'(i);
        end
        issue(1'b0, 16'h0200, 8'hFF, 3'd7);
        @(negedge clk1);
        @(negedge clk1);
        mem_ready = 1'b0;
        check("rst_mid_addr2", mem_addr, 16'h0202);
        @(negedge clk1);
        check("rst_mid_addr2_hold", mem_addr, 16'h0202);
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_mem_valid", mem_valid, 0);
        check("rst_mid_mem_we", mem_we, 0);
        check("rst_mid_rf_we", rf_we, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_mem_addr", mem_addr, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        check("rst_mid_r0", rf[0], 16'hC200);
        check("rst_mid_r1", rf[1], 16'hC201);
        check("rst_mid_r2", rf[2], 16'h0000);
        check("rst_mid_r7", rf[7], 16'h0000);
        check("rst_mid_access_cnt", acc_q.size(), 2);
        issue(1'b0, 16'h0010, 8'h02, 3'd6);
        wait_done("post_rst_latency", 1, 2 + UPD);
        check("post_rst_r1", rf[1], 16'hAAAA);

        // LM base 0x0020, rlist 0x0E, base register R1
        mem[16'h0020] = 16'hD001;
        mem[16'h0021] = 16'hD002;
        mem[16'h0022] = 16'hD003;
        issue(1'b0, 16'h0020, 8'h0E, 3'd1);
        wait_done("upd_latency", 1, 4 + UPD);
        check("upd_r1", rf[1], UPD ? 16'h0023 : 16'hD001);
        check("upd_r2", rf[2], 16'hD002);
        check("upd_r3", rf[3], 16'hD003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
